// File: rtl/decimal_key_bcd_encoder_pkg.sv
// ============================================================================
// Module      : decimal_key_bcd_encoder_pkg
// Description : Shared types, widths and digit helpers for the key encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decimal_key_bcd_encoder_pkg;

    localparam int BCD_W    = 4;
    localparam int NUM_KEYS = 10;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Lowest pressed key wins when several lines are active.
    function automatic logic [BCD_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] pat);
        logic [BCD_W-1:0] w_idx;
        w_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pat[i]) begin
                w_idx = BCD_W'(i);
            end
        end
        return w_idx;
    endfunction

    function automatic logic multi_set(input logic [NUM_KEYS-1:0] pat);
        return (pat & (pat - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decimal_key_bcd_encoder_if.sv
// ============================================================================
// Module      : decimal_key_bcd_encoder_if
// Description : Valid/ready digit output channel of the key encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decimal_key_bcd_encoder_if;
    import decimal_key_bcd_encoder_pkg::*;

    logic [BCD_W-1:0] bcd_out;
    logic             out_valid;
    logic             multi_err;
    logic             out_ready;

    modport master (
        output bcd_out,
        output out_valid,
        output multi_err,
        input  out_ready
    );

    modport slave (
        input  bcd_out,
        input  out_valid,
        input  multi_err,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-stage synchronizer, both stages cleared by async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/decimal_key_bcd_encoder.sv
// ============================================================================
// Module      : decimal_key_bcd_encoder
// Description : Debounced decimal keypad to BCD encoder, one digit per press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_key_bcd_encoder
    import decimal_key_bcd_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [NUM_KEYS-1:0] key_in,
    decimal_key_bcd_encoder_if.master out_if
);

    localparam logic [CNT_W-1:0] c_debounce    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_debounce_m1 = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    logic [NUM_KEYS-1:0] w_sk;
    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_KEYS-1:0] r_pat;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_valid;
    logic                r_multi;

    sync_2ff #(
        .WIDTH (NUM_KEYS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_in),
        .o_q (w_sk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pat   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sk != '0) begin
                        r_pat   <= w_sk;
                        r_count <= CNT_W'(1);
                        r_state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_sk == '0) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_sk != r_pat) begin
                        r_pat   <= w_sk;
                        r_count <= CNT_W'(1);
                    end else if (r_count >= c_debounce) begin
                        // Digit fields are frozen here and held until the next press.
                        r_bcd   <= lowest_key(r_pat);
                        r_multi <= multi_set(r_pat);
                        r_valid <= 1'b1;
                        r_count <= '0;
                        r_state <= ST_EMIT;
                    end else if (r_count != c_cnt_max) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (r_valid && out_if.out_ready) begin
                        r_valid <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Any key activity restarts the release window.
                    if (w_sk != '0) begin
                        r_count <= '0;
                    end else if (r_count >= c_debounce_m1) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_count != c_cnt_max) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.bcd_out   = r_bcd;
    assign out_if.out_valid = r_valid;
    assign out_if.multi_err = r_multi;

endmodule

`default_nettype wire

// File: tb/tb_decimal_key_bcd_encoder.sv
// ============================================================================
// Module      : tb_decimal_key_bcd_encoder
// Description : Scenario bench for the key encoder with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_key_bcd_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] key_in = '0;

    decimal_key_bcd_encoder_if bus ();

    decimal_key_bcd_encoder #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .out_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: sk is key_in two edges late; a digit appears once the same
    // nonzero pattern has been seen D+1 samples in a row while armed, and
    // re-arming needs D zero samples after the handshake.
    logic [9:0] m_s1, m_s2, m_sk, m_pat;
    int         m_phase;  // 0 armed, 1 holding digit, 2 waiting for release
    int         m_run, m_zrun;
    logic       m_valid, m_multi;
    logic [3:0] m_bcd;
    logic [3:0] m_log[$];
    logic [3:0] d_log[$];

    function automatic logic [3:0] first_key(input logic [9:0] p);
        int k;
        k = 0;
        while (k < 9 && !p[k]) k++;
        return 4'(k);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_pat = '0;
            m_phase = 0; m_run = 0; m_zrun = 0;
            m_valid = 1'b0; m_multi = 1'b0; m_bcd = '0;
        end else begin
            m_sk = m_s2;
            m_s2 = m_s1;
            m_s1 = key_in;
            if (m_phase == 0) begin
                if (m_sk == '0) m_run = 0;
                else if (m_run > 0 && m_sk == m_pat) m_run++;
                else begin m_pat = m_sk; m_run = 1; end
                if (m_run == D + 1) begin
                    m_phase = 1; m_valid = 1'b1;
                    m_bcd = first_key(m_sk);
                    m_multi = ($countones(m_sk) > 1);
                end
            end else if (m_phase == 1) begin
                if (bus.out_ready) begin
                    m_log.push_back(m_bcd);
                    m_phase = 2; m_valid = 1'b0; m_zrun = 0;
                end
            end else begin
                if (m_sk != '0) m_zrun = 0;
                else m_zrun++;
                if (m_zrun == D) begin m_phase = 0; m_run = 0; end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) d_log.push_back(bus.bcd_out);
    end

    task automatic advance(input logic [9:0] k, input logic r);
        key_in = k;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) advance(10'h000, 1'b1);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_async got v=%b bcd=%0d me=%b want 0/0/0", bus.out_valid, bus.bcd_out, bus.multi_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(10'h000, 1'b1);
            n_checks++;
            if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_idle got v=%b bcd=%0d me=%b want 0/0/0", bus.out_valid, bus.bcd_out, bus.multi_err);
            end
        end
    endtask

    task automatic test_single_key();
        int n0;
        n0 = d_log.size();
        for (int e = 1; e <= 20; e++) begin
            advance(10'b00_0010_0000, 1'b1);
            n_checks++;
            if (bus.out_valid !== (e == 7)) begin
                n_errors++;
                $display("FAIL single_valid edge=%0d got %b want %b", e, bus.out_valid, (e == 7));
            end
            if (e == 7) begin
                n_checks++;
                if (bus.bcd_out !== 4'd5 || bus.multi_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_digit got bcd=%0d me=%b want 5/0", bus.bcd_out, bus.multi_err);
                end
            end
            n_checks++;
            if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== {m_valid, m_bcd, m_multi}) begin
                n_errors++;
                $display("FAIL model_single edge=%0d got %b/%0d/%b want %b/%0d/%b", e, bus.out_valid, bus.bcd_out, bus.multi_err, m_valid, m_bcd, m_multi);
            end
        end
        n_checks++;
        if (d_log.size() - n0 != 1) begin
            n_errors++;
            $display("FAIL single_count got %0d transfers want 1", d_log.size() - n0);
        end
        settle();
    endtask

    task automatic test_bounce();
        int n0;
        logic [9:0] k;
        n0 = d_log.size();
        for (int e = 1; e <= 25; e++) begin
            k = (e <= 6 && (e % 2) == 0) ? 10'h000 : 10'h008;
            advance(k, 1'b1);
            n_checks++;
            if (bus.out_valid !== (e == 13)) begin
                n_errors++;
                $display("FAIL bounce_valid edge=%0d got %b want %b", e, bus.out_valid, (e == 13));
            end
            n_checks++;
            if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== {m_valid, m_bcd, m_multi}) begin
                n_errors++;
                $display("FAIL model_bounce edge=%0d got %b/%0d/%b want %b/%0d/%b", e, bus.out_valid, bus.bcd_out, bus.multi_err, m_valid, m_bcd, m_multi);
            end
        end
        n_checks++;
        if (d_log.size() - n0 != 1 || d_log[d_log.size()-1] !== 4'd3) begin
            n_errors++;
            $display("FAIL bounce_digit got %0d transfers last=%0d want 1 transfer of 3", d_log.size() - n0, d_log[d_log.size()-1]);
        end
        settle();
    endtask

    task automatic test_multi_key();
        int w;
        w = 0;
        while (!bus.out_valid && w < 20) begin advance(10'b10_0001_0000, 1'b0); w++; end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd4 || bus.multi_err !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_digit got v=%b bcd=%0d me=%b want 1/4/1", bus.out_valid, bus.bcd_out, bus.multi_err);
        end
        advance(10'b10_0001_0000, 1'b1);
        settle();
        n_checks++;
        if (bus.bcd_out !== 4'd4 || bus.multi_err !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_hold got bcd=%0d me=%b want 4/1", bus.bcd_out, bus.multi_err);
        end
    endtask

    task automatic test_backpressure();
        int w, n0;
        w = 0;
        while (!bus.out_valid && w < 20) begin advance(10'h040, 1'b0); w++; end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL backp_wait got valid=%b want 1 within 20 cycles", bus.out_valid);
        end
        n0 = d_log.size();
        for (int i = 0; i < 20; i++) begin
            advance(10'h200, 1'b0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.bcd_out !== 4'd6 || bus.multi_err !== 1'b0) begin
                n_errors++;
                $display("FAIL backp_hold cyc=%0d got %b/%0d/%b want 1/6/0", i, bus.out_valid, bus.bcd_out, bus.multi_err);
            end
        end
        advance(10'h200, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || d_log.size() - n0 != 1) begin
            n_errors++;
            $display("FAIL backp_xfer got valid=%b transfers=%0d want 0/1", bus.out_valid, d_log.size() - n0);
        end
        for (int i = 0; i < 15; i++) begin
            advance(10'h200, 1'b1);
            n_checks++;
            if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== {m_valid, m_bcd, m_multi}) begin
                n_errors++;
                $display("FAIL model_backp cyc=%0d got %b/%0d/%b want %b/%0d/%b", i, bus.out_valid, bus.bcd_out, bus.multi_err, m_valid, m_bcd, m_multi);
            end
        end
        n_checks++;
        if (d_log.size() - n0 != 1) begin
            n_errors++;
            $display("FAIL backp_release got %0d transfers want 1", d_log.size() - n0);
        end
        settle();
    endtask

    task automatic test_reset_in_emit();
        int w, n0;
        w = 0;
        while (!bus.out_valid && w < 20) begin advance(10'h004, 1'b0); w++; end
        n0 = d_log.size();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL emit_reset got v=%b bcd=%0d me=%b want 0/0/0", bus.out_valid, bus.bcd_out, bus.multi_err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            advance(10'h004, 1'b0);
            n_checks++;
            if (bus.out_valid !== (e >= 7)) begin
                n_errors++;
                $display("FAIL reemit_valid edge=%0d got %b want %b", e, bus.out_valid, (e >= 7));
            end
            n_checks++;
            if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== {m_valid, m_bcd, m_multi}) begin
                n_errors++;
                $display("FAIL model_reemit edge=%0d got %b/%0d/%b want %b/%0d/%b", e, bus.out_valid, bus.bcd_out, bus.multi_err, m_valid, m_bcd, m_multi);
            end
        end
        n_checks++;
        if (bus.bcd_out !== 4'd2 || d_log.size() != n0) begin
            n_errors++;
            $display("FAIL reemit_digit got bcd=%0d transfers=%0d want 2/0", bus.bcd_out, d_log.size() - n0);
        end
        advance(10'h004, 1'b1);
        settle();
    endtask

    task automatic test_repeat(input int gap, input int want);
        int w, n0;
        n0 = d_log.size();
        w = 0;
        while (!bus.out_valid && w < 20) begin advance(10'h200, 1'b1); w++; end
        advance(10'h200, 1'b1);
        for (int i = 0; i < gap; i++) advance(10'h000, 1'b1);
        for (int i = 0; i < 15; i++) advance(10'h001, 1'b1);
        n_checks++;
        if (d_log.size() - n0 != want) begin
            n_errors++;
            $display("FAIL repeat_count gap=%0d got %0d transfers want %0d", gap, d_log.size() - n0, want);
        end else begin
            n_checks++;
            if (d_log[n0] !== 4'd9 || (want == 2 && d_log[n0+1] !== 4'd0)) begin
                n_errors++;
                $display("FAIL repeat_digits gap=%0d got %0d,%0d want 9,0", gap, d_log[n0], d_log[d_log.size()-1]);
            end
        end
        settle();
    endtask

    task automatic test_random();
        int cyc, len, sel;
        logic [9:0] k;
        cyc = 0;
        while (cyc < 400) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) k = 10'h000;
            else if (sel < 8) k = 10'(1) << $urandom_range(0, 9);
            else k = 10'($urandom_range(1, 1023));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                advance(k, ($urandom_range(0, 3) != 0));
                cyc++;
                n_checks++;
                if ({bus.out_valid, bus.bcd_out, bus.multi_err} !== {m_valid, m_bcd, m_multi}) begin
                    n_errors++;
                    $display("FAIL model_random cyc=%0d got %b/%0d/%b want %b/%0d/%b", cyc, bus.out_valid, bus.bcd_out, bus.multi_err, m_valid, m_bcd, m_multi);
                end
            end
        end
        settle();
    endtask

    task automatic test_transfer_log();
        n_checks++;
        if (d_log.size() != m_log.size()) begin
            n_errors++;
            $display("FAIL log_size got %0d want %0d", d_log.size(), m_log.size());
        end else begin
            for (int i = 0; i < d_log.size(); i++) begin
                n_checks++;
                if (d_log[i] !== m_log[i]) begin
                    n_errors++;
                    $display("FAIL log_entry idx=%0d got %0d want %0d", i, d_log[i], m_log[i]);
                end
            end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_backpressure();
        test_reset_in_emit();
        test_repeat(4, 2);
        test_repeat(3, 1);
        test_random();
        test_transfer_log();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/decimal_key_bcd_encoder.md
DECIMAL_KEY_BCD_ENCODER -- requirements
Module: decimal_key_bcd_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive synchronized cycles a key pattern must be stable before acceptance; legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all flops sample on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port key_in, input, 10 bits, asynchronous decimal key lines; bit k high means key k is pressed.
REQ-005 The block SHALL have port out_ready, input, 1 bit, consumer ready.
REQ-006 The block SHALL have port bcd_out, output, 4 bits, encoded digit 0..9.
REQ-007 The block SHALL have port out_valid, output, 1 bit, bcd_out holds a digit awaiting handshake.
REQ-008 The block SHALL have port multi_err, output, 1 bit, the emitted digit came from a pattern with more than one key set.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; all logic below uses the synchronized value (sk).
REQ-010 The FSM SHALL have states IDLE, DEBOUNCE, EMIT and RELEASE.
REQ-011 IDLE: sk nonzero -> capture sk into pat, load count 1, go to DEBOUNCE; sk zero -> stay.
REQ-012 DEBOUNCE: sk zero -> IDLE; sk nonzero and not equal to pat -> recapture pat, count 1, stay; sk equal to pat -> increment count; count reaching DEBOUNCE_CYCLES -> go to EMIT.
REQ-013 On entry to EMIT, bcd_out SHALL be the index of the lowest set bit of pat, and multi_err SHALL be 1 when pat has two or more bits set; both are registered and held constant through EMIT.
REQ-014 out_valid SHALL be 1 exactly while in EMIT; transfer occurs on a rising edge with out_valid and out_ready both 1, then the FSM goes to RELEASE.
REQ-015 out_valid SHALL NOT drop, and bcd_out and multi_err SHALL NOT change, before transfer, regardless of key_in activity.
REQ-016 RELEASE: count consecutive cycles with sk zero and restart the count on any nonzero sk; count reaching DEBOUNCE_CYCLES -> IDLE. A held key therefore produces exactly one digit.
REQ-017 Latency: with key_in stable and nonzero from before edge 1 and the FSM in IDLE, out_valid SHALL first be 1 after edge DEBOUNCE_CYCLES+3.
REQ-018 Simultaneous events: out_ready high on the edge EMIT is entered SHALL NOT transfer; transfer needs out_valid already 1.
REQ-019 Outside EMIT, bcd_out and multi_err SHALL keep the last emitted value.
REQ-020 Counter width SHALL be 8 bits and SHALL saturate; no wrap-around.

Reset
REQ-021 rst high SHALL immediately force state IDLE, count 0, pat 0, both synchronizer stages 0, bcd_out 4'd0, out_valid 0, multi_err 0.
REQ-022 Reset asserted mid-operation, including in EMIT with an untransferred digit, SHALL discard that digit; after deassertion a still-held key is treated as a new press.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, the constant BCD_W = 4, and the constant NUM_KEYS = 10.
REQ-024 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, parameterized by width and with async reset clearing both stages.

Verification
REQ-025 Single key: key_in = 10'b00_0010_0000 held, out_ready = 1, DEBOUNCE_CYCLES = 4 -> out_valid high after edge 7 for one cycle, bcd_out = 5, multi_err = 0, no second digit while the key stays held.
REQ-026 Bounce: key_in toggles 10'h008 and 0 every cycle for 6 cycles, then holds 10'h008 -> exactly one digit, bcd_out = 3, emitted 7 edges after the final stable hold begins.
REQ-027 Multi-key: key_in = 10'b10_0001_0000 -> bcd_out = 4, multi_err = 1.
REQ-028 Backpressure: out_ready = 0 for 20 cycles after valid while key_in changes to 10'h200 -> out_valid stays 1 and bcd_out stays at the original digit; out_ready = 1 -> one transfer, then RELEASE.
REQ-029 Reset in EMIT: rst pulsed while out_valid = 1, key still held -> outputs 0 immediately; the same digit is re-emitted DEBOUNCE_CYCLES+3 edges after release of rst.
REQ-030 Repeat: press key 9, release for at least 4 cycles, press key 0 -> two transfers, 9 then 0; a release shorter than 4 cycles -> only 9.
